// File: rtl/uart_tx_word_serializer_pkg.sv
// Shared definitions for the UART word serializer: FSM state encoding,
// byte/word geometry, and a helper that sizes the inter-byte gap counter.
package uart_tx_word_serializer_pkg;

    localparam int NB_STATE       = 3;
    localparam int NB_BYTE_DEF    = 8;
    localparam int NB_DATA_DEF    = 32;
    localparam int BYTES_PER_WORD = NB_DATA_DEF / NB_BYTE_DEF;
    localparam int NB_IDX         = 2;

    typedef enum logic [NB_STATE-1:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // A gap of zero still needs a 1-bit counter so the port stays legal.
    function automatic int gap_width(input int n_clocks);
        return (n_clocks > 0) ? $clog2(n_clocks + 1) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_word_serializer_if.sv
// Request/byte handshake bundle between the debug unit, the serializer and
// the UART transmitter core.
interface uart_tx_word_serializer_if #(
    parameter int NB_DATA = uart_tx_word_serializer_pkg::NB_BYTE_DEF *
                            uart_tx_word_serializer_pkg::BYTES_PER_WORD,
    parameter int NB_BYTE = uart_tx_word_serializer_pkg::NB_BYTE_DEF
);

    logic [NB_DATA-1:0] i_data;
    logic               i_tx_32b_start;
    logic               i_tx_8b_start;
    logic               i_tx_done;
    logic [NB_BYTE-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_tx_32b_done;
    logic               o_tx_8b_done;
    logic               o_busy;

    modport master (
        output i_data, i_tx_32b_start, i_tx_8b_start, i_tx_done,
        input  o_tx_data, o_tx_start, o_tx_32b_done, o_tx_8b_done, o_busy
    );

    modport slave (
        input  i_data, i_tx_32b_start, i_tx_8b_start, i_tx_done,
        output o_tx_data, o_tx_start, o_tx_32b_done, o_tx_8b_done, o_busy
    );

endinterface

// File: rtl/uart_tx_word_serializer_gap_counter.sv
// Loadable down-counter with zero flag; load has priority over decrement and
// the count saturates at zero.
module uart_tx_word_serializer_gap_counter #(
    parameter int NB_COUNT = 3
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_load,
    input  logic [NB_COUNT-1:0] i_load_value,
    input  logic                i_dec,
    output logic [NB_COUNT-1:0] o_count,
    output logic                o_zero
);

    logic [NB_COUNT-1:0] count_d;
    logic [NB_COUNT-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_load_value;
        end else if (i_dec && (count_q != '0)) begin
            count_d = count_q - NB_COUNT'(1);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;
    assign o_zero  = (count_q == '0);

endmodule

// File: rtl/uart_tx_word_serializer.sv
// Splits a 32-bit word (or a single byte) into LSB-first bytes for the UART
// transmitter core, with a configurable idle gap between bytes.
module uart_tx_word_serializer #(
    parameter int NB_DATA               = uart_tx_word_serializer_pkg::NB_DATA_DEF,
    parameter int NB_BYTE               = uart_tx_word_serializer_pkg::NB_BYTE_DEF,
    parameter int N_CLOCKS_BETWEEN_DATA = 4
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    uart_tx_word_serializer_if.slave      bus
);

    import uart_tx_word_serializer_pkg::*;

    localparam int                NB_GAP   = gap_width(N_CLOCKS_BETWEEN_DATA);
    localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'((NB_DATA / NB_BYTE) - 1);

    state_t             state_d,    state_q;
    logic [NB_DATA-1:0] word_d,     word_q;
    logic [NB_IDX-1:0]  idx_d,      idx_q;
    logic [NB_IDX-1:0]  last_idx_d, last_idx_q;
    logic               is_32b_d,   is_32b_q;
    logic [NB_BYTE-1:0] tx_data_d,  tx_data_q;
    logic               tx_start_d, tx_start_q;
    logic               done_32b_d, done_32b_q;
    logic               done_8b_d,  done_8b_q;
    logic               busy_d,     busy_q;

    logic               gap_load;
    logic               gap_dec;
    logic [NB_GAP-1:0]  gap_count;
    logic               gap_zero;

    uart_tx_word_serializer_gap_counter #(
        .NB_COUNT (NB_GAP)
    ) u_gap_counter (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_load       (gap_load),
        .i_load_value (NB_GAP'(N_CLOCKS_BETWEEN_DATA)),
        .i_dec        (gap_dec),
        .o_count      (gap_count),
        .o_zero       (gap_zero)
    );

    // Outputs are registered from the next state, so SEND/DONE pulses line up
    // with the cycle the FSM actually occupies those states.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        idx_d      = idx_q;
        last_idx_d = last_idx_q;
        is_32b_d   = is_32b_q;
        gap_load   = 1'b0;
        gap_dec    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_tx_32b_start) begin
                    word_d     = bus.i_data;
                    idx_d      = '0;
                    last_idx_d = LAST_IDX;
                    is_32b_d   = 1'b1;
                    state_d    = ST_SEND;
                end else if (bus.i_tx_8b_start) begin
                    word_d     = bus.i_data;
                    idx_d      = '0;
                    last_idx_d = '0;
                    is_32b_d   = 1'b0;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.i_tx_done) begin
                    if (idx_q == last_idx_q) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + NB_IDX'(1);
                        if (N_CLOCKS_BETWEEN_DATA == 0) begin
                            state_d = ST_SEND;
                        end else begin
                            gap_load = 1'b1;
                            state_d  = ST_GAP;
                        end
                    end
                end
            end
            ST_GAP: begin
                // Leaving on the cycle the count steps 1 -> 0 gives exactly
                // N idle GAP cycles before the next SEND.
                gap_dec = 1'b1;
                if ((gap_count == NB_GAP'(1)) || gap_zero) begin
                    state_d = ST_SEND;
                end
            end
            ST_DONE: begin
                idx_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        tx_data_d  = (state_d == ST_SEND) ? word_d[NB_BYTE*int'(idx_d) +: NB_BYTE] : tx_data_q;
        tx_start_d = (state_d == ST_SEND);
        done_32b_d = (state_d == ST_DONE) && is_32b_d;
        done_8b_d  = (state_d == ST_DONE) && !is_32b_d;
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            word_q     <= '0;
            idx_q      <= '0;
            last_idx_q <= '0;
            is_32b_q   <= 1'b0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            done_32b_q <= 1'b0;
            done_8b_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            last_idx_q <= last_idx_d;
            is_32b_q   <= is_32b_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            done_32b_q <= done_32b_d;
            done_8b_q  <= done_8b_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.o_tx_data     = tx_data_q;
    assign bus.o_tx_start    = tx_start_q;
    assign bus.o_tx_32b_done = done_32b_q;
    assign bus.o_tx_8b_done  = done_8b_q;
    assign bus.o_busy        = busy_q;

endmodule

// File: tb/tb_uart_tx_word_serializer.sv
// Directed bench for the UART word serializer: a UART-core stand-in answers
// each byte with i_tx_done, and a monitor logs bytes, gaps and done pulses.
module tb_uart_tx_word_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_word_serializer_if #(.NB_DATA(32), .NB_BYTE(8)) bus ();
    uart_tx_word_serializer_if #(.NB_DATA(32), .NB_BYTE(8)) bus0 ();

    uart_tx_word_serializer #(
        .NB_DATA               (32),
        .NB_BYTE               (8),
        .N_CLOCKS_BETWEEN_DATA (4)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    uart_tx_word_serializer #(
        .NB_DATA               (32),
        .NB_BYTE               (8),
        .N_CLOCKS_BETWEEN_DATA (0)
    ) dut_n0 (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus0)
    );

    int         n_checks   = 0;
    int         n_fail     = 0;
    logic [7:0] byte_q[$];
    int         gap_q[$];
    int         n_start    = 0;
    int         n_done32   = 0;
    int         n_done8    = 0;
    int         n_unstable = 0;
    int         done_cyc   = 0;
    bit         done_valid = 1'b0;
    bit         resp_en    = 1'b1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // UART core stand-in: acknowledges each byte seven cycles after its start.
    initial begin
        forever begin
            @(negedge clk);
            if (resp_en && bus.o_tx_start) begin
                repeat (7) @(negedge clk);
                bus.i_tx_done = 1'b1;
                done_cyc      = cyc;
                done_valid    = 1'b1;
                @(negedge clk);
                bus.i_tx_done = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (bus.o_tx_start) begin
                byte_q.push_back(bus.o_tx_data);
                n_start++;
                if (done_valid) gap_q.push_back(cyc - done_cyc);
            end
            if (bus.o_tx_32b_done) begin
                n_done32++;
                done_valid = 1'b0;
            end
            if (bus.o_tx_8b_done) begin
                n_done8++;
                done_valid = 1'b0;
            end
            if (bus.i_tx_done && (byte_q.size() > 0) && (bus.o_tx_data != byte_q[$])) n_unstable++;
        end
    end

    function automatic logic [31:0] byteAt(input int i);
        return (i < byte_q.size()) ? 32'(byte_q[i]) : 32'hDEAD;
    endfunction

    task automatic clearLog();
        byte_q.delete();
        gap_q.delete();
        n_start    = 0;
        n_done32   = 0;
        n_done8    = 0;
        done_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic s32, input logic s8, input logic [31:0] data);
        bus.i_data         = data;
        bus.i_tx_32b_start = s32;
        bus.i_tx_8b_start  = s8;
        step();
        bus.i_tx_32b_start = 1'b0;
        bus.i_tx_8b_start  = 1'b0;
        bus.i_data         = ~data;
        checkOutput("start_latency", 32'(bus.o_tx_start), 32'd1);
        checkOutput("busy_rise", 32'(bus.o_busy), 32'd1);
    endtask

    task automatic waitDone(input string tag);
        int k = 0;
        while (!(bus.o_tx_32b_done || bus.o_tx_8b_done) && k < 400) begin
            step();
            k++;
        end
        if (k >= 400) begin
            checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            checkOutput({tag, "_busy_at_done"}, 32'(bus.o_busy), 32'd1);
        end
        step();
        checkOutput({tag, "_busy_after"}, 32'(bus.o_busy), 32'd0);
    endtask

    task automatic checkBytes(input string tag, input logic [31:0] word, input int n);
        checkOutput({tag, "_count"}, 32'(byte_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            checkOutput({tag, "_byte"}, byteAt(i), (word >> (8 * i)) & 32'hFF);
        end
    endtask

    initial begin
        int         k;
        int         gap;
        logic [31:0] d0;

        bus.i_data          = '0;
        bus.i_tx_32b_start  = 1'b0;
        bus.i_tx_8b_start   = 1'b0;
        bus.i_tx_done       = 1'b0;
        bus0.i_data         = '0;
        bus0.i_tx_32b_start = 1'b0;
        bus0.i_tx_8b_start  = 1'b0;
        bus0.i_tx_done      = 1'b0;

        rst = 1'b1;
        repeat (3) step();
        checkOutput("rst_tx_start", 32'(bus.o_tx_start), 32'd0);
        checkOutput("rst_tx_data", 32'(bus.o_tx_data), 32'd0);
        checkOutput("rst_done32", 32'(bus.o_tx_32b_done), 32'd0);
        checkOutput("rst_done8", 32'(bus.o_tx_8b_done), 32'd0);
        checkOutput("rst_busy", 32'(bus.o_busy), 32'd0);
        checkOutput("rst_n0_busy", 32'(bus0.o_busy), 32'd0);
        rst = 1'b0;
        repeat (2) step();

        $display("[TB] 32b word AABBCCDD");
        clearLog();
        applyStimulus(1'b1, 1'b0, 32'hAABBCCDD);
        waitDone("t1");
        checkOutput("t1_byte0", byteAt(0), 32'hDD);
        checkOutput("t1_byte3", byteAt(3), 32'hAA);
        checkBytes("t1", 32'hAABBCCDD, 4);
        checkOutput("t1_done32", 32'(n_done32), 32'd1);
        checkOutput("t1_done8", 32'(n_done8), 32'd0);
        checkOutput("t1_gap_count", 32'(gap_q.size()), 32'd3);
        for (int i = 0; i < gap_q.size(); i++) checkOutput("t1_gap_n4", 32'(gap_q[i]), 32'd5);

        $display("[TB] 8b byte from 11223344");
        clearLog();
        applyStimulus(1'b0, 1'b1, 32'h11223344);
        waitDone("t2");
        checkBytes("t2", 32'h00000044, 1);
        checkOutput("t2_done8", 32'(n_done8), 32'd1);
        checkOutput("t2_done32", 32'(n_done32), 32'd0);

        $display("[TB] simultaneous 32b and 8b starts");
        clearLog();
        applyStimulus(1'b1, 1'b1, 32'h55667788);
        waitDone("t3");
        checkBytes("t3", 32'h55667788, 4);
        checkOutput("t3_done32", 32'(n_done32), 32'd1);
        checkOutput("t3_done8", 32'(n_done8), 32'd0);

        $display("[TB] start ignored while busy");
        clearLog();
        applyStimulus(1'b1, 1'b0, 32'h0BADF00D);
        k = 0;
        while (byte_q.size() < 2 && k < 200) begin
            step();
            k++;
        end
        repeat (2) step();
        bus.i_data         = 32'h01020304;
        bus.i_tx_32b_start = 1'b1;
        step();
        bus.i_tx_32b_start = 1'b0;
        waitDone("t4");
        repeat (20) step();
        checkBytes("t4", 32'h0BADF00D, 4);
        checkOutput("t4_starts", 32'(n_start), 32'd4);
        checkOutput("t4_done32", 32'(n_done32), 32'd1);

        $display("[TB] back-to-back bytes with zero gap");
        d0                  = 32'h0A0B0C0D;
        bus0.i_data         = d0;
        bus0.i_tx_32b_start = 1'b1;
        step();
        bus0.i_tx_32b_start = 1'b0;
        for (int b = 0; b < 4; b++) begin
            k = 0;
            while (!bus0.o_tx_start && k < 50) begin
                step();
                k++;
            end
            checkOutput("n0_byte", 32'(bus0.o_tx_data), (d0 >> (8 * b)) & 32'hFF);
            repeat (2) step();
            bus0.i_tx_done = 1'b1;
            gap = 0;
            do begin
                step();
                gap++;
                bus0.i_tx_done = 1'b0;
            end while (!(bus0.o_tx_start || bus0.o_tx_32b_done) && gap < 20);
            checkOutput("n0_gap", 32'(gap), 32'd1);
        end
        checkOutput("n0_done32", 32'(bus0.o_tx_32b_done), 32'd1);
        step();

        $display("[TB] reset during inter-byte gap");
        clearLog();
        applyStimulus(1'b1, 1'b0, 32'h12345678);
        k = 0;
        while (!(byte_q.size() == 2 && bus.i_tx_done) && k < 200) begin
            step();
            k++;
        end
        checkOutput("t6_reach_gap", 32'(k < 200), 32'd1);
        rst = 1'b1;
        step();
        checkOutput("t6_tx_start", 32'(bus.o_tx_start), 32'd0);
        checkOutput("t6_tx_data", 32'(bus.o_tx_data), 32'd0);
        checkOutput("t6_busy", 32'(bus.o_busy), 32'd0);
        checkOutput("t6_done32", 32'(bus.o_tx_32b_done), 32'd0);
        checkOutput("t6_done8", 32'(bus.o_tx_8b_done), 32'd0);
        rst = 1'b0;
        repeat (20) step();
        checkOutput("t6_no_done", 32'(n_done32 + n_done8), 32'd0);
        checkOutput("t6_no_more_bytes", 32'(n_start), 32'd2);
        clearLog();
        applyStimulus(1'b1, 1'b0, 32'hEEFFDDCC);
        waitDone("t6b");
        checkBytes("t6b", 32'hEEFFDDCC, 4);
        checkOutput("t6b_done32", 32'(n_done32), 32'd1);

        checkOutput("data_stable", 32'(n_unstable), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
